sr_flop_bank: RTL and testbench

//   Bank of WIDTH clocked set/reset flip-flops with a selectable resolution
//   for the S=R=1 conflict case. Adds clock enable, per-bit change pulses,

---
 rtl/sr_flop_bank.sv | 151 +++++++++++++++
 tb/tb_sr_flop_bank.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flop_bank.sv
// sr_flop_bank: a bank of WIDTH clocked set/reset flip-flops.
// When s and r are both high, MODE decides the outcome: hold, set, reset or toggle.
// The bank also provides:
//   - a clock enable,
//   - per-bit change pulses,
//   - sticky per-bit conflict flags,
//   - a saturating count of conflict cycles.
module sr_flop_bank #(
    parameter int               WIDTH   = 4,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_flop_bank: MODE must be 0..3");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("sr_flop_bank: WIDTH must be at least 1");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_flop_bank: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]       MODE_SEL = 2'(MODE);
    localparam logic [1:0]       MODE_HOLD   = 2'd0;
    localparam logic [1:0]       MODE_SET    = 2'd1;
    localparam logic [1:0]       MODE_RESET  = 2'd2;
    localparam logic [1:0]       MODE_TOGGLE = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_reg;
    logic [WIDTH-1:0] conflict_reg;
    logic [WIDTH-1:0] conflict_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] both;
    logic             any_c;

    // Next value of one SR bit.
    // Enable is handled outside this function.
    function automatic logic sr_next(input logic cur, input logic set_req, input logic rst_req);
        logic nxt;
        nxt = cur;
        unique case ({set_req, rst_req})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                unique case (MODE_SEL)
                    MODE_HOLD:   nxt = cur;
                    MODE_SET:    nxt = 1'b1;
                    MODE_RESET:  nxt = 1'b0;
                    MODE_TOGGLE: nxt = ~cur;
                    default:     nxt = cur;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Bits that request set and reset in the same cycle.
    assign both = s & r;

    // Conflicts only count while the bank is enabled.
    // Several conflicting bits in one cycle still count as one conflict cycle.
    assign any_c = en & (|both);

    // ------------------------------------------------------------------
    // Per-bit update logic
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        // Each bit resolves its own request.
        // With the enable low, the bit keeps its value.
        assign q_next[gi] = en ? sr_next(q_reg[gi], s[gi], r[gi]) : q_reg[gi];

        // Sticky flag.
        // A conflict in the same cycle as clr_err keeps the flag set.
        assign conflict_next[gi] = (conflict_reg[gi] & ~clr_err) | both[gi] & en;
    end

    // ------------------------------------------------------------------
    // Conflict-cycle counter
    // ------------------------------------------------------------------
    // clr_err takes priority over counting.
    // A new conflict in the clear cycle restarts the count at one.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr_err) begin
            cnt_next = any_c ? CNT_ONE : '0;
        end else if (any_c && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State registers, asynchronously reset.
    // chg marks the bits that differ between the old and new q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg        <= RST_VAL;
            chg_reg      <= '0;
            conflict_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            q_reg        <= q_next;
            chg_reg      <= q_next ^ q_reg;
            conflict_reg <= conflict_next;
            cnt_reg      <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // qn is taken straight from q, so it adds no cycle of delay.
    assign q            = q_reg;
    assign qn           = ~q_reg;
    assign chg          = chg_reg;
    assign conflict     = conflict_reg;
    assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Testbench for sr_flop_bank.
// Several configurations share one stimulus bus: the widths, modes, counter
// widths and reset values all differ.
// A driver pushes the expected outputs from a behavioural model into a
// scoreboard queue, and a monitor pops each entry and compares it.
module tb_sr_flop_bank;

    localparam int NI = 8;

    function automatic int cfg_w(input int i);
        case (i)
            5:       return 1;
            6, 7:    return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_mode(input int i);
        case (i)
            1, 6:    return 1;
            2, 7:    return 2;
            3, 5:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_cw(input int i);
        case (i)
            4:       return 2;
            6:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [15:0] cfg_rv(input int i);
        case (i)
            0:       return 16'h000A;
            5:       return 16'h0001;
            6:       return 16'hA5C3;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] cfg_mask(input int i);
        int w;
        w = cfg_w(i);
        return (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 32'd1);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] s = '0;
    logic [15:0] r = '0;
    logic        clr_err = 1'b0;

    logic [15:0] q_o  [NI];
    logic [15:0] qn_o [NI];
    logic [15:0] chg_o[NI];
    logic [15:0] cf_o [NI];
    logic [7:0]  cnt_o[NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int          W    = cfg_w(gi);
        localparam int          M    = cfg_mode(gi);
        localparam int          CW   = cfg_cw(gi);
        localparam logic [15:0] RV16 = cfg_rv(gi);
        logic [W-1:0]  q_l, qn_l, chg_l, cf_l;
        logic [CW-1:0] cnt_l;
        sr_flop_bank #(
            .WIDTH(W), .MODE(M), .RST_VAL(RV16[W-1:0]), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .s(s[W-1:0]), .r(r[W-1:0]),
            .clr_err(clr_err), .q(q_l), .qn(qn_l), .chg(chg_l),
            .conflict(cf_l), .conflict_cnt(cnt_l)
        );
        assign q_o[gi]   = 16'(q_l);
        assign qn_o[gi]  = 16'(qn_l);
        assign chg_o[gi] = 16'(chg_l);
        assign cf_o[gi]  = 16'(cf_l);
        assign cnt_o[gi] = 8'(cnt_l);
    end

    // Scoreboard: NI entries per sample point, in instance order.
    typedef struct packed {
        logic [15:0] q;
        logic [15:0] qn;
        logic [15:0] chg;
        logic [15:0] cf;
        logic [7:0]  cnt;
    } exp_t;
    exp_t sb[$];

    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    bit   armed = 1'b0;
    event rst_ev;

    // Reference model state
    logic [15:0] m_q  [NI];
    logic [15:0] m_chg[NI];
    logic [15:0] m_cf [NI];
    int          m_cnt[NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_q[i]   = cfg_rv(i) & cfg_mask(i);
            m_chg[i] = '0;
            m_cf[i]  = '0;
            m_cnt[i] = 0;
        end
    endtask

    // One rising edge from the behavioural rules: the S/R truth table,
    // sticky flags, and a clamped count of conflict cycles.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            logic [15:0] msk, old, nq;
            bit any;
            msk = cfg_mask(i);
            old = m_q[i];
            nq  = old;
            any = 1'b0;
            if (en) begin
                for (int b = 0; b < cfg_w(i); b++) begin
                    if (s[b] && !r[b])      nq[b] = 1'b1;
                    else if (!s[b] && r[b]) nq[b] = 1'b0;
                    else if (s[b] && r[b]) begin
                        any = 1'b1;
                        case (cfg_mode(i))
                            1:       nq[b] = 1'b1;
                            2:       nq[b] = 1'b0;
                            3:       nq[b] = ~old[b];
                            default: nq[b] = old[b];
                        endcase
                    end
                end
            end
            m_chg[i] = nq ^ old;
            m_q[i]   = nq;
            m_cf[i]  = (clr_err ? 16'h0 : m_cf[i]) | (en ? (s & r & msk) : 16'h0);
            if (clr_err)                                         m_cnt[i] = any ? 1 : 0;
            else if (any && m_cnt[i] < (1 << cfg_cw(i)) - 1)    m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic push_exp();
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e.q   = m_q[i];
            e.qn  = ~m_q[i] & cfg_mask(i);
            e.chg = m_chg[i];
            e.cf  = m_cf[i];
            e.cnt = 8'(m_cnt[i]);
            sb.push_back(e);
        end
        armed = 1'b1;
    endtask

    // One stimulus cycle: set the inputs on the falling edge.
    // Optionally raise rst mid-cycle.
    // Push the expectation for the coming rising edge.
    task automatic step(input bit do_rst, input logic e, input logic [15:0] sv,
                        input logic [15:0] rv, input logic c);
        @(negedge clk);
        rst     = 1'b0;
        en      = e;
        s       = sv;
        r       = rv;
        clr_err = c;
        if (do_rst) begin
            #2;
            rst = 1'b1;
            model_reset();
            push_exp();
            ->rst_ev;
        end
        if (rst) model_reset();
        else     model_edge();
        push_exp();
    endtask

    task automatic spot(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: sample 1 time unit after each rising edge or reset assertion.
    // Pop the expected entries and compare them with the outputs.
    initial begin
        forever begin
            @(posedge clk or rst_ev);
            #1;
            if (armed) begin
                for (int i = 0; i < NI; i++) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow inst%0d got empty required entry", i);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checks++;
                        if (q_o[i] !== e.q) begin
                            errors++;
                            $display("FAIL inst%0d q got %h required %h", i, q_o[i], e.q);
                        end
                        checks++;
                        if (qn_o[i] !== e.qn) begin
                            errors++;
                            $display("FAIL inst%0d qn got %h required %h", i, qn_o[i], e.qn);
                        end
                        checks++;
                        if (chg_o[i] !== e.chg) begin
                            errors++;
                            $display("FAIL inst%0d chg got %h required %h", i, chg_o[i], e.chg);
                        end
                        checks++;
                        if (cf_o[i] !== e.cf) begin
                            errors++;
                            $display("FAIL inst%0d conflict got %h required %h", i, cf_o[i], e.cf);
                        end
                        checks++;
                        if (cnt_o[i] !== e.cnt) begin
                            errors++;
                            $display("FAIL inst%0d cnt got %0d required %0d", i, cnt_o[i], e.cnt);
                        end
                    end
                end
                txn++;
                $display("txn %0d t=%0t rst=%b en=%b s=%h r=%h clr=%b q0=%h cnt0=%0d q6=%h cnt6=%0d",
                         txn, $time, rst, en, s, r, clr_err, q_o[0], cnt_o[0], q_o[6], cnt_o[6]);
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted mid-cycle, before any clock edge
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        spot("rst_q",   q_o[0],   16'h000A);
        spot("rst_qn",  qn_o[0],  16'h0005);
        spot("rst_chg", chg_o[0], 16'h0000);
        spot("rst_cf",  cf_o[0],  16'h0000);
        spot("rst_cnt", 16'(cnt_o[0]), 16'h0000);

        // Clear q, then the basic set/repeat/reset sequence
        step(1'b0, 1'b1, 16'h0000, 16'h000F, 1'b0);
        step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0);
        after_edge();
        spot("basic_set_q",   q_o[0],   16'h0001);
        spot("basic_set_chg", chg_o[0], 16'h0001);
        step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0);
        after_edge();
        spot("basic_rep_chg", chg_o[0], 16'h0000);
        step(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);
        after_edge();
        spot("basic_rst_q",   q_o[0],   16'h0000);
        spot("basic_rst_chg", chg_o[0], 16'h0001);

        // Conflict resolution in every mode
        step(1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0);
        after_edge();
        spot("mode3_first_q", q_o[3], 16'h0003);
        step(1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0);
        after_edge();
        spot("mode0_q", q_o[0], 16'h0000);
        spot("mode1_q", q_o[1], 16'h0003);
        spot("mode2_q", q_o[2], 16'h0000);
        spot("mode3_q", q_o[3], 16'h0000);
        for (int i = 0; i < 4; i++) begin
            spot("modes_cf",  cf_o[i],        16'h0003);
            spot("modes_cnt", 16'(cnt_o[i]),  16'h0002);
        end

        // Enable low: nothing moves
        repeat (5) step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        after_edge();
        spot("en_q",   q_o[1],        16'h0003);
        spot("en_chg", chg_o[3],      16'h0000);
        spot("en_cf",  cf_o[0],       16'h0003);
        spot("en_cnt", 16'(cnt_o[0]), 16'h0002);

        // Saturation and clear on the 2-bit counter instance
        repeat (5) step(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        after_edge();
        spot("sat_cnt", 16'(cnt_o[4]), 16'h0003);
        step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);
        after_edge();
        spot("clr_cnt", 16'(cnt_o[4]), 16'h0000);
        spot("clr_cf",  cf_o[4],       16'h0000);
        step(1'b0, 1'b1, 16'h0004, 16'h0004, 1'b1);
        after_edge();
        spot("clrc_cnt", 16'(cnt_o[4]), 16'h0001);
        spot("clrc_cf",  cf_o[4],       16'h0004);

        // Random traffic, including resets in the middle of operation
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 64) == 0, ($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                 ($urandom % 16) == 0);
        end

        after_edge();
        #2;
        armed = 1'b0;
        spot("sb_drained", 16'(sb.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
